// File: rtl/pipeline_pkg.sv
// Shared pipeline types: MEM-stage FSM encoding, memory control bundle, word width.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package pipeline_pkg;

   localparam int unsigned WORD_W = 32;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   // Control bits carried from execute into the memory stage.
   typedef struct packed {
      logic       memread;
      logic       memwrite;
      logic       regwrite;
      logic       memtoreg;
      logic [4:0] write_reg;
   } mem_ctrl_t;

   // Word accesses only: any nonzero byte offset is a misaligned access.
   function automatic logic is_misaligned(input logic [1:0] byte_off);
      return byte_off != 2'b00;
   endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Bus-transaction watchdog: counts enabled cycles, flags the LIMIT-th one.
// Latency: expire is combinational in the cycle the count would reach LIMIT.
// Backpressure: none; load clears the count and has priority over enable.
// Ports: clk/rst (async active-high), load (clear), enable (count this cycle),
//        expire (this enabled cycle is the LIMIT-th since load).
module mem_timeout_ctr #(
   parameter int unsigned LIMIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic enable,
   output logic expire
);

   logic [7:0] count;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= 8'd0;
      end else if (load) begin
         count <= 8'd0;
      end else if (enable) begin
         count <= count + 8'd1;
      end
   end

   // count holds the number of enabled cycles already elapsed, so the
   // current enabled cycle is the LIMIT-th when count == LIMIT-1.
   assign expire = enable && (count == 8'(LIMIT - 1));

endmodule

// File: rtl/mem_access.sv
// MIPS memory stage: passes ALU results through, runs lw/sw on a req/ack port.
// Latency: 1 cycle for non-memory ops; memory ops 1 cycle after ack/timeout.
// Backpressure: ex_ready low for the whole ACCESS state; execute must hold.
// Ports: ex_* (execute inputs + ex_ready), flush, dmem_* (data memory port),
//        wb_* (registered writeback bundle), err_misalign (pulse),
//        err_timeout (sticky until rst).
module mem_access
   import pipeline_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 16,
   parameter int unsigned ADDR_W         = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_valid,
   output logic              ex_ready,
   input  logic [31:0]       ex_alu_result,
   input  logic [31:0]       ex_write_data,
   input  logic              ex_memread,
   input  logic              ex_memwrite,
   input  logic              ex_regwrite,
   input  logic              ex_memtoreg,
   input  logic [4:0]        ex_write_reg,
   input  logic              flush,
   output logic              dmem_req,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] dmem_addr,
   output logic [31:0]       dmem_wdata,
   input  logic [31:0]       dmem_rdata,
   input  logic              dmem_ack,
   output logic              wb_valid,
   output logic              wb_regwrite,
   output logic [4:0]        wb_write_reg,
   output logic [31:0]       wb_data,
   output logic              err_misalign,
   output logic              err_timeout
);

   state_t            state;
   mem_ctrl_t         ctrl_q;
   logic [WORD_W-1:0] alu_q;
   logic              req_q;
   logic              killed_q;

   logic accept;
   logic is_mem;
   logic start_access;
   logic killed_now;
   logic is_load;
   logic tmo_en;
   logic tmo_expire;

   assign accept       = ex_valid && ex_ready && !flush;
   assign is_mem       = ex_memread || ex_memwrite;
   assign start_access = accept && is_mem && !is_misaligned(ex_alu_result[1:0]);
   // A flush seen on the completing cycle kills the instruction as well.
   assign killed_now   = killed_q || flush;
   // Store wins when both memread and memwrite are set.
   assign is_load      = ctrl_q.memread && !ctrl_q.memwrite;
   assign tmo_en       = (state == ACCESS) && !dmem_ack;

   // Request drops combinationally on the ack so memory never sees a second beat.
   assign dmem_req  = req_q && !dmem_ack;
   assign dmem_addr = {alu_q[ADDR_W-1:2], 2'b00};

   mem_timeout_ctr #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .load   (start_access),
      .enable (tmo_en),
      .expire (tmo_expire)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         ex_ready     <= 1'b1;
         ctrl_q       <= '0;
         alu_q        <= '0;
         req_q        <= 1'b0;
         killed_q     <= 1'b0;
         dmem_we      <= 1'b0;
         dmem_wdata   <= '0;
         wb_valid     <= 1'b0;
         wb_regwrite  <= 1'b0;
         wb_write_reg <= '0;
         wb_data      <= '0;
         err_misalign <= 1'b0;
         err_timeout  <= 1'b0;
      end else begin
         wb_valid     <= 1'b0;
         err_misalign <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (!is_mem) begin
                     wb_valid     <= 1'b1;
                     wb_regwrite  <= ex_regwrite;
                     wb_write_reg <= ex_write_reg;
                     wb_data      <= ex_alu_result;
                  end else if (is_misaligned(ex_alu_result[1:0])) begin
                     wb_valid     <= 1'b1;
                     wb_regwrite  <= 1'b0;
                     wb_write_reg <= ex_write_reg;
                     wb_data      <= ex_alu_result;
                     err_misalign <= 1'b1;
                  end else begin
                     ctrl_q     <= '{memread:   ex_memread,
                                     memwrite:  ex_memwrite,
                                     regwrite:  ex_regwrite,
                                     memtoreg:  ex_memtoreg,
                                     write_reg: ex_write_reg};
                     alu_q      <= ex_alu_result;
                     dmem_we    <= ex_memwrite;
                     dmem_wdata <= ex_write_data;
                     killed_q   <= 1'b0;
                     req_q      <= 1'b1;
                     ex_ready   <= 1'b0;
                     state      <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               if (dmem_ack || tmo_expire) begin
                  state    <= IDLE;
                  req_q    <= 1'b0;
                  ex_ready <= 1'b1;
                  killed_q <= 1'b0;
                  wb_valid <= !killed_now;
                  // Ack has priority over a same-cycle expiry.
                  if (!dmem_ack) begin
                     err_timeout <= 1'b1;
                  end
                  if (!killed_now) begin
                     wb_write_reg <= ctrl_q.write_reg;
                     if (dmem_ack) begin
                        wb_regwrite <= ctrl_q.regwrite && !ctrl_q.memwrite;
                        wb_data     <= (is_load && ctrl_q.memtoreg) ? dmem_rdata : alu_q;
                     end else begin
                        wb_regwrite <= 1'b0;
                        wb_data     <= alu_q;
                     end
                  end
               end else begin
                  killed_q <= killed_now;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with a short timeout.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: the stimulus holds off while ex_ready is low.
module tb_mem_access;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid;
   logic        ex_ready;
   logic [31:0] ex_alu_result;
   logic [31:0] ex_write_data;
   logic        ex_memread;
   logic        ex_memwrite;
   logic        ex_regwrite;
   logic        ex_memtoreg;
   logic [4:0]  ex_write_reg;
   logic        flush;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [31:0] dmem_rdata;
   logic        dmem_ack;
   logic        wb_valid;
   logic        wb_regwrite;
   logic [4:0]  wb_write_reg;
   logic [31:0] wb_data;
   logic        err_misalign;
   logic        err_timeout;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_access #(
      .TIMEOUT_CYCLES (4),
      .ADDR_W         (32)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .ex_valid      (ex_valid),
      .ex_ready      (ex_ready),
      .ex_alu_result (ex_alu_result),
      .ex_write_data (ex_write_data),
      .ex_memread    (ex_memread),
      .ex_memwrite   (ex_memwrite),
      .ex_regwrite   (ex_regwrite),
      .ex_memtoreg   (ex_memtoreg),
      .ex_write_reg  (ex_write_reg),
      .flush         (flush),
      .dmem_req      (dmem_req),
      .dmem_we       (dmem_we),
      .dmem_addr     (dmem_addr),
      .dmem_wdata    (dmem_wdata),
      .dmem_rdata    (dmem_rdata),
      .dmem_ack      (dmem_ack),
      .wb_valid      (wb_valid),
      .wb_regwrite   (wb_regwrite),
      .wb_write_reg  (wb_write_reg),
      .wb_data       (wb_data),
      .err_misalign  (err_misalign),
      .err_timeout   (err_timeout)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic rd, input logic wr, input logic rw,
                        input logic m2r, input logic [31:0] alu, input logic [31:0] wd,
                        input logic [4:0] rg);
      ex_valid      = v;
      ex_memread    = rd;
      ex_memwrite   = wr;
      ex_regwrite   = rw;
      ex_memtoreg   = m2r;
      ex_alu_result = alu;
      ex_write_data = wd;
      ex_write_reg  = rg;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst        = 1'b1;
      flush      = 1'b0;
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      #3;
      chk("rst_ex_ready", {31'b0, ex_ready}, 32'd1);
      chk("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
      chk("rst_wb_valid", {31'b0, wb_valid}, 32'd0);
      chk("rst_err_timeout", {31'b0, err_timeout}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      tick();

      // ALU passthrough, then a back-to-back second op.
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0007, 32'h0, 5'd5);
      tick();
      chk("alu_wb_valid", {31'b0, wb_valid}, 32'd1);
      chk("alu_wb_data", wb_data, 32'h7);
      chk("alu_wb_reg", {27'b0, wb_write_reg}, 32'd5);
      chk("alu_wb_regwrite", {31'b0, wb_regwrite}, 32'd1);
      chk("alu_ex_ready", {31'b0, ex_ready}, 32'd1);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0009, 32'h0, 5'd6);
      tick();
      chk("b2b_wb_valid", {31'b0, wb_valid}, 32'd1);
      chk("b2b_wb_data", wb_data, 32'h9);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      tick();
      chk("idle_wb_valid", {31'b0, wb_valid}, 32'd0);
      chk("idle_wb_data_hold", wb_data, 32'h9);

      // lw at 0x100, ack in the 4th ACCESS cycle.
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0100, 32'h0, 5'd8);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      for (int i = 0; i < 3; i++) begin
         chk("lw_ex_ready_low", {31'b0, ex_ready}, 32'd0);
         chk("lw_req", {31'b0, dmem_req}, 32'd1);
         chk("lw_addr", dmem_addr, 32'h100);
         chk("lw_we", {31'b0, dmem_we}, 32'd0);
         tick();
      end
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hDEAD_BEEF;
      #1;
      chk("lw_req_drop_on_ack", {31'b0, dmem_req}, 32'd0);
      chk("lw_ex_ready_low4", {31'b0, ex_ready}, 32'd0);
      tick();
      dmem_ack = 1'b0;
      chk("lw_wb_valid", {31'b0, wb_valid}, 32'd1);
      chk("lw_wb_data", wb_data, 32'hDEAD_BEEF);
      chk("lw_wb_regwrite", {31'b0, wb_regwrite}, 32'd1);
      chk("lw_wb_reg", {27'b0, wb_write_reg}, 32'd8);
      chk("lw_ex_ready_back", {31'b0, ex_ready}, 32'd1);
      tick();
      chk("lw_wb_pulse", {31'b0, wb_valid}, 32'd0);

      // Misaligned sw at 0x102.
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0102, 32'h1234_5678, 5'd9);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      chk("mis_req", {31'b0, dmem_req}, 32'd0);
      chk("mis_err", {31'b0, err_misalign}, 32'd1);
      chk("mis_wb_valid", {31'b0, wb_valid}, 32'd1);
      chk("mis_wb_regwrite", {31'b0, wb_regwrite}, 32'd0);
      chk("mis_ex_ready", {31'b0, ex_ready}, 32'd1);
      tick();
      chk("mis_err_pulse", {31'b0, err_misalign}, 32'd0);

      // sw at 0x200 with no ack: times out after 4 ACCESS cycles.
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'hCAFE_F00D, 5'd0);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      chk("sw_we", {31'b0, dmem_we}, 32'd1);
      chk("sw_wdata", dmem_wdata, 32'hCAFE_F00D);
      chk("sw_err_timeout_pre", {31'b0, err_timeout}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         chk("tmo_req_high", {31'b0, dmem_req}, 32'd1);
         chk("tmo_ex_ready_low", {31'b0, ex_ready}, 32'd0);
         tick();
      end
      chk("tmo_req_drop", {31'b0, dmem_req}, 32'd0);
      chk("tmo_err", {31'b0, err_timeout}, 32'd1);
      chk("tmo_wb_valid", {31'b0, wb_valid}, 32'd1);
      chk("tmo_wb_regwrite", {31'b0, wb_regwrite}, 32'd0);
      chk("tmo_ex_ready", {31'b0, ex_ready}, 32'd1);
      tick();
      chk("tmo_err_sticky", {31'b0, err_timeout}, 32'd1);
      chk("tmo_wb_pulse", {31'b0, wb_valid}, 32'd0);

      // Ack in IDLE is ignored.
      dmem_ack = 1'b1;
      tick();
      dmem_ack = 1'b0;
      chk("idle_ack_wb_valid", {31'b0, wb_valid}, 32'd0);
      chk("idle_ack_ex_ready", {31'b0, ex_ready}, 32'd1);

      // Flush in IDLE blocks a lw accept.
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0400, 32'h0, 5'd4);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      chk("flush_idle_req", {31'b0, dmem_req}, 32'd0);
      chk("flush_idle_wb_valid", {31'b0, wb_valid}, 32'd0);
      chk("flush_idle_ex_ready", {31'b0, ex_ready}, 32'd1);

      // lw flushed mid-ACCESS, ack in ACCESS cycle 2.
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0300, 32'h0, 5'd7);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      flush = 1'b1;
      chk("kill_req_c1", {31'b0, dmem_req}, 32'd1);
      tick();
      flush = 1'b0;
      chk("kill_req_held", {31'b0, dmem_req}, 32'd1);
      dmem_ack   = 1'b1;
      dmem_rdata = 32'h1111_2222;
      #1;
      chk("kill_req_drop", {31'b0, dmem_req}, 32'd0);
      tick();
      dmem_ack = 1'b0;
      chk("kill_wb_valid", {31'b0, wb_valid}, 32'd0);
      chk("kill_wb_data_hold", wb_data, 32'h200);
      chk("kill_ex_ready", {31'b0, ex_ready}, 32'd1);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0055, 32'h0, 5'd3);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      chk("after_kill_wb_valid", {31'b0, wb_valid}, 32'd1);
      chk("after_kill_wb_data", wb_data, 32'h55);

      // Async reset in the middle of ACCESS.
      drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0500, 32'h0, 5'd2);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      chk("rst_mid_req_pre", {31'b0, dmem_req}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_mid_req_async", {31'b0, dmem_req}, 32'd0);
      chk("rst_mid_ex_ready", {31'b0, ex_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b0;
      tick();
      chk("rst_rel_err_timeout", {31'b0, err_timeout}, 32'd0);
      chk("rst_rel_req", {31'b0, dmem_req}, 32'd0);
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_00AA, 32'h0, 5'd1);
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
      chk("rst_rel_alu_wb_valid", {31'b0, wb_valid}, 32'd1);
      chk("rst_rel_alu_wb_data", wb_data, 32'hAA);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
